// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter onto a single-ported data memory.
// m0 is a word-only fetch port. m1 is a load/store port with byte/half/word
// sizes, sign/zero extension and read-modify-write for sub-word stores.
module dm_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_sext,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [9:0]  dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_din,
  output logic        dm_wr,
  input  logic [31:0] dm_dout
);

  typedef enum logic [2:0] {StIdle, StAddr, StCapt, StWrite, StAck} state_e;

  state_e      state_q, state_d;
  logic        prio_q;   // 1: m1 wins a tie
  logic        gnt_q;    // 1: m1 owns the transaction
  logic [11:0] addr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        we_q;
  logic        err_q;
  logic [3:0]  be_q;
  logic [31:0] din_q;    // raw store data, replaced by the merged word for RMW
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;

  logic        req_any;
  logic        gnt_m1;
  logic [11:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_we;
  logic        sel_err;
  logic [3:0]  sel_be;
  logic [31:0] lane_mask;
  logic [31:0] wrep;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] ld_ext;
  logic        unused_addr;

  assign unused_addr = ^{m0_addr[31:12], m0_addr[1:0], m1_addr[31:12]};

  // Arbitration and selection of the winner's request fields.
  always_comb begin
    req_any  = m0_req | m1_req;
    gnt_m1   = m1_req & (~m0_req | prio_q);
    sel_addr = gnt_m1 ? m1_addr[11:0] : {m0_addr[11:2], 2'b00};
    sel_size = gnt_m1 ? m1_size : 2'b10;
    sel_we   = gnt_m1 & m1_we;
    sel_err  = gnt_m1 & ((m1_size == 2'b11) ||
                         (m1_size == 2'b01 && sel_addr[0]) ||
                         (m1_size == 2'b10 && sel_addr[1:0] != 2'b00));
    sel_be   = 4'b0000;
    if (!sel_err) begin
      case (sel_size)
        2'b00:   sel_be = 4'b0001 << sel_addr[1:0];
        2'b01:   sel_be = sel_addr[1] ? 4'b1100 : 4'b0011;
        default: sel_be = 4'b1111;
      endcase
    end
  end

  // Store merge and load extraction for the latched access.
  always_comb begin
    lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    case (size_q)
      2'b00:   wrep = {4{din_q[7:0]}};
      2'b01:   wrep = {2{din_q[15:0]}};
      default: wrep = din_q;
    endcase
    merged  = (dm_dout & ~lane_mask) | (wrep & lane_mask);
    shifted = dm_dout >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_ext = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_ext = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  // Next-state logic; word stores skip the read and errors go straight to ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_any) begin
          if (sel_err)                         state_d = StAck;
          else if (sel_we && sel_size == 2'b10) state_d = StWrite;
          else                                 state_d = StAddr;
        end
      end
      StAddr:  state_d = StCapt;
      StCapt:  state_d = we_q ? StWrite : StAck;
      StWrite: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, request latches, read capture and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prio_q     <= 1'b0;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      be_q       <= '0;
      din_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_any) begin
        gnt_q  <= gnt_m1;
        addr_q <= sel_addr;
        size_q <= sel_size;
        sext_q <= gnt_m1 & m1_sext;
        we_q   <= sel_we;
        err_q  <= sel_err;
        be_q   <= sel_be;
        din_q  <= gnt_m1 ? m1_wdata : '0;
      end
      if (state_q == StCapt) begin
        if (we_q)       din_q      <= merged;
        else if (gnt_q) m1_rdata_q <= ld_ext;
        else            m0_rdata_q <= dm_dout;
      end
      if (state_q == StAck) prio_q <= ~gnt_q;
    end
  end

  // Memory-side and requester-side outputs decoded from the current state.
  always_comb begin
    dm_addr  = (state_q != StIdle) ? addr_q[11:2] : '0;
    dm_be    = (state_q != StIdle) ? be_q : '0;
    dm_din   = din_q;
    dm_wr    = (state_q == StWrite) && !rst;
    m0_ack   = (state_q == StAck) && !gnt_q;
    m1_ack   = (state_q == StAck) && gnt_q;
    m1_err   = (state_q == StAck) && gnt_q && err_q;
    m0_rdata = m0_rdata_q;
    m1_rdata = m1_rdata_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory and an
// expected-ack scoreboard.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [1:0]  m1_size;
  logic        m1_sext;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;
  logic [9:0]  dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_din;
  logic        dm_wr;
  logic [31:0] dm_dout;

  always #5 clk = ~clk;

  dm_arbiter u_dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_size  (m1_size),
    .m1_sext  (m1_sext),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .m1_rdata (m1_rdata),
    .dm_addr  (dm_addr),
    .dm_be    (dm_be),
    .dm_din   (dm_din),
    .dm_wr    (dm_wr),
    .dm_dout  (dm_dout)
  );

  // Synchronous memory: one-cycle read latency, byte-lane writes, bench preload.
  logic [31:0] mem [1024];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (dm_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_be[i]) mem[dm_addr][8*i +: 8] <= dm_din[8*i +: 8];
      end
    end
    dm_dout <= mem[dm_addr];
  end

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          both_seen;
  bit          wr_seen;
  logic [3:0]  wr_be;
  logic [31:0] wr_din;
  logic [31:0] m1_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (m0_ack && m1_ack) both_seen = 1'b1;
    if (dm_wr) begin
      wr_seen = 1'b1;
      wr_be   = dm_be;
      wr_din  = dm_din;
    end
  endtask

  task automatic push(input bit port, input bit err, input logic [31:0] rdata, input int lat);
    exp_t e;
    e.port  = port;
    e.err   = err;
    e.rdata = rdata;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // Pops one scoreboard entry per ack; latency counted in cycles after the grant edge.
  task automatic wait_acks(input int n, input int budget, input string tag);
    int   got = 0;
    int   lat = 0;
    exp_t e;
    while (got < n && lat < budget) begin
      tick();
      lat++;
      if (m0_ack || m1_ack) begin
        got++;
        check({tag, " sb nonempty"}, {31'b0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, " port"}, {31'b0, m1_ack}, {31'b0, e.port});
          if (e.port) begin
            check({tag, " m1_err"}, {31'b0, m1_err}, {31'b0, e.err});
            check({tag, " m1_rdata"}, m1_rdata, e.rdata);
          end else begin
            check({tag, " m0_rdata"}, m0_rdata, e.rdata);
          end
          if (e.lat > 0) check({tag, " latency"}, lat, e.lat);
        end
      end
    end
    check({tag, " ack count"}, got, n);
  endtask

  task automatic finish_txn(input string tag);
    wait_acks(1, 12, tag);
    tick();
    check({tag, " ack pulse"}, {31'b0, m0_ack | m1_ack}, 32'd0);
  endtask

  // Present a request, let the grant edge pass, then scramble the inputs.
  task automatic issue_m1(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m1_req   = 1'b1;
    m1_we    = we;
    m1_size  = size;
    m1_sext  = sext;
    m1_addr  = addr;
    m1_wdata = wdata;
    @(posedge clk);
    #1;
    m1_req   = 1'b0;
    m1_we    = ~we;
    m1_size  = ~size;
    m1_sext  = ~sext;
    m1_addr  = ~addr;
    m1_wdata = ~wdata;
  endtask

  task automatic issue_m0(input logic [31:0] addr);
    m0_req  = 1'b1;
    m0_addr = addr;
    @(posedge clk);
    #1;
    m0_req  = 1'b0;
    m0_addr = ~addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acks;
    rst = 1'b1; m0_req = 1'b0; m0_addr = '0; m1_req = 1'b0; m1_we = 1'b0;
    m1_size = '0; m1_sext = 1'b0; m1_addr = '0; m1_wdata = '0;
    both_seen = 1'b0; wr_seen = 1'b0; wr_be = '0; wr_din = '0; m1_last = '0;
    pre_we = 1'b1; pre_addr = 10'd4; pre_data = 32'h1122_3344;
    @(posedge clk); #1;
    pre_addr = 10'd5; pre_data = 32'h5566_7788;
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst m0_ack", {31'b0, m0_ack}, 32'd0);
    check("rst m1_ack", {31'b0, m1_ack}, 32'd0);
    check("rst m1_err", {31'b0, m1_err}, 32'd0);
    check("rst m0_rdata", m0_rdata, 32'd0);
    check("rst m1_rdata", m1_rdata, 32'd0);
    check("rst dm_wr", {31'b0, dm_wr}, 32'd0);
    check("rst dm_be", {28'b0, dm_be}, 32'd0);
    check("rst dm_addr", {22'b0, dm_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // m0 fetch of word 4
    push(1'b0, 1'b0, 32'h1122_3344, 3);
    issue_m0(32'h010);
    finish_txn("m0 fetch");

    // Byte store via read-modify-write; upper wdata bits must be ignored
    wr_seen = 1'b0;
    push(1'b1, 1'b0, m1_last, 4);
    issue_m1(1'b1, 2'b00, 1'b0, 32'h011, 32'h1234_56AA);
    finish_txn("sb 0x011");
    check("sb wr_seen", {31'b0, wr_seen}, 32'd1);
    check("sb dm_be", {28'b0, wr_be}, 32'h2);
    check("sb dm_din", wr_din, 32'h1122_AA44);

    // Sub-word loads with both extensions
    m1_last = 32'hFFFF_FFAA; push(1'b1, 1'b0, m1_last, 3);
    issue_m1(1'b0, 2'b00, 1'b1, 32'h011, 32'h0);
    finish_txn("lb sext 0x011");
    m1_last = 32'h0000_00AA; push(1'b1, 1'b0, m1_last, 3);
    issue_m1(1'b0, 2'b00, 1'b0, 32'h011, 32'h0);
    finish_txn("lbu 0x011");
    m1_last = 32'hFFFF_AA44; push(1'b1, 1'b0, m1_last, 3);
    issue_m1(1'b0, 2'b01, 1'b1, 32'h010, 32'h0);
    finish_txn("lh sext 0x010");
    m1_last = 32'h0000_1122; push(1'b1, 1'b0, m1_last, 3);
    issue_m1(1'b0, 2'b01, 1'b1, 32'h012, 32'h0);
    finish_txn("lh sext 0x012");
    m1_last = 32'h0000_0011; push(1'b1, 1'b0, m1_last, 3);
    issue_m1(1'b0, 2'b00, 1'b0, 32'h013, 32'h0);
    finish_txn("lbu 0x013");

    // Misaligned and illegal accesses: error ack one cycle after grant
    wr_seen = 1'b0;
    push(1'b1, 1'b1, m1_last, 1);
    issue_m1(1'b1, 2'b01, 1'b0, 32'h013, 32'h0000_BEEF);
    finish_txn("sh misaligned");
    check("sh misaligned no write", {31'b0, wr_seen}, 32'd0);
    push(1'b1, 1'b1, m1_last, 1);
    issue_m1(1'b0, 2'b11, 1'b0, 32'h010, 32'h0);
    finish_txn("size 11");
    push(1'b1, 1'b1, m1_last, 1);
    issue_m1(1'b0, 2'b10, 1'b0, 32'h016, 32'h0);
    finish_txn("lw misaligned");

    // Reset during WRITE drops the store and the ack
    wr_seen = 1'b0;
    issue_m1(1'b1, 2'b10, 1'b0, 32'h014, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    check("rst in write dm_wr", {31'b0, dm_wr}, 32'd0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_ack || m1_ack) acks++;
    end
    check("rst in write acks", acks, 0);
    check("rst in write wr_seen", {31'b0, wr_seen}, 32'd0);
    check("rst in write dm_be", {28'b0, dm_be}, 32'd0);
    rst = 1'b0;
    m1_last = 32'h5566_7788; push(1'b1, 1'b0, m1_last, 3);
    issue_m1(1'b0, 2'b10, 1'b0, 32'h014, 32'h0);
    finish_txn("lw after aborted store");

    // Word store then load back
    wr_seen = 1'b0;
    push(1'b1, 1'b0, m1_last, 2);
    issue_m1(1'b1, 2'b10, 1'b0, 32'h014, 32'hDEAD_BEEF);
    finish_txn("sw 0x014");
    check("sw dm_be", {28'b0, wr_be}, 32'hF);
    check("sw dm_din", wr_din, 32'hDEAD_BEEF);
    m1_last = 32'hDEAD_BEEF; push(1'b1, 1'b0, m1_last, 3);
    issue_m1(1'b0, 2'b10, 1'b0, 32'h014, 32'h0);
    finish_txn("lw 0x014");

    // Both ports held from reset alternate, starting with m0
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h010;
    m1_req = 1'b1; m1_we = 1'b0; m1_size = 2'b10; m1_sext = 1'b0; m1_addr = 32'h014;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    both_seen = 1'b0;
    push(1'b0, 1'b0, 32'h1122_AA44, 0);
    push(1'b1, 1'b0, 32'hDEAD_BEEF, 0);
    push(1'b0, 1'b0, 32'h1122_AA44, 0);
    push(1'b1, 1'b0, 32'hDEAD_BEEF, 0);
    wait_acks(4, 40, "round robin");
    m0_req = 1'b0;
    m1_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m0_ack || m1_ack) acks++;
    end
    check("rr no extra acks", acks, 0);
    check("rr never two acks", {31'b0, both_seen}, 32'd0);
    check("sb drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 m0_req  in  1  instruction-fetch port read request (word only).
REQ-005 m0_addr  in  32  byte address; bits [11:2] used, [1:0] ignored.
REQ-006 m0_ack  out  1  one-cycle completion pulse for m0.
REQ-007 m0_rdata  out  32  fetched word; registered, held until next m0 completion.
REQ-008 m1_req  in  1  data port request.
REQ-009 m1_we  in  1  1 = store, 0 = load.
REQ-010 m1_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 m1_sext  in  1  loads only: 1 sign-extend, 0 zero-extend the sub-word.
REQ-012 m1_addr  in  32  byte address; bits [11:0] used.
REQ-013 m1_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-014 m1_ack  out  1  one-cycle completion pulse for m1.
REQ-015 m1_err  out  1  high with m1_ack when the access was misaligned or illegal.
REQ-016 m1_rdata  out  32  extended load result; registered, held until next m1 load completion.
REQ-017 dm_addr  out  10  word address to data memory (addr[11:2]).
REQ-018 dm_be  out  4  byte-lane mask for the current access.
REQ-019 dm_din  out  32  write data to data memory.
REQ-020 dm_wr  out  1  data memory write enable.
REQ-021 dm_dout  in  32  data memory read word, valid the cycle after dm_addr is presented.

Function
REQ-022 FSM states SHALL be IDLE, ADDR, CAPT, WRITE, ACK; one transaction in flight at a time.
REQ-023 In IDLE the block SHALL sample m0_req/m1_req; on a grant it latches the winner's address, size, sext, we and wdata.
REQ-024 Arbitration SHALL be round-robin: a priority pointer selects the port that wins ties, flipping to the other port after each completion; a lone requester always wins.
REQ-025 Load or m0 fetch: IDLE -> ADDR -> CAPT -> ACK -> IDLE; ack SHALL assert in the 3rd cycle after the granting edge.
REQ-026 Word store: IDLE -> WRITE -> ACK -> IDLE; dm_din = wdata, dm_be = 1111.
REQ-027 Byte/half store (read-modify-write): IDLE -> ADDR -> CAPT -> WRITE -> ACK; CAPT registers dm_dout with the addressed lanes replaced by wdata; WRITE drives that merged word.
REQ-028 Lane mapping SHALL be little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 0 -> [15:0], offset 2 -> [31:16].
REQ-029 dm_addr SHALL equal the latched addr[11:2] in ADDR, CAPT, WRITE and ACK, and 0 in IDLE.
REQ-030 dm_wr SHALL be high only in WRITE and only when rst is low.
REQ-031 dm_be SHALL equal the latched lane mask in non-IDLE states and 0000 in IDLE; m0 mask is 1111.
REQ-032 Loads SHALL capture rdata at the CAPT->ACK edge from dm_dout, shifted to bit 0 and extended per sext.
REQ-033 Misaligned or illegal m1 access (half with addr[0]=1, word with addr[1:0]!=0, size 11): IDLE -> ACK with m1_err=1, no dm_wr, m1_rdata unchanged.
REQ-034 Exactly one of m0_ack/m1_ack SHALL pulse in ACK, for one cycle, for the granted port.
REQ-035 Requester inputs SHALL be ignored after grant; deasserting req mid-transaction SHALL NOT abort it.
REQ-036 A req held high through ACK SHALL be treated as a new request when sampled in the following IDLE.

Reset
REQ-037 On a posedge with rst=1: state IDLE, priority to m0, m0_ack=m1_ack=m1_err=0, m0_rdata=m1_rdata=0, latched registers 0.
REQ-038 Reset during any state SHALL abandon the transaction without ack; a reset coinciding with WRITE SHALL suppress that write (memory unchanged).

Verification
REQ-039 Memory word 4 = 0x11223344; m0 read 0x010 -> m0_ack 3 cycles after grant, m0_rdata=0x11223344.
REQ-040 m1 store byte 0x011, wdata 0xAA -> dm_be=0010, dm_din=0x1122AA44; then load byte 0x011 sext=1 -> 0xFFFFFFAA; sext=0 -> 0x000000AA.
REQ-041 m0_req and m1_req held high from reset -> grants m0, m1, m0, m1 alternate; never two acks in one cycle.
REQ-042 m1 half store at 0x013 -> m1_ack with m1_err=1 one cycle after grant; dm_wr never high.
REQ-043 m1 word store 0x014 = 0xDEADBEEF with rst=1 in the WRITE cycle -> dm_wr=0, no ack, state IDLE; a later load of 0x014 returns the prior contents.
REQ-044 m1 word store 0x014 = 0xDEADBEEF, then word load 0x014 -> dm_be=1111 on the store, m1_rdata=0xDEADBEEF, m1_err=0.
